// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-to-1 valid/ready stream multiplexer with a single registered
//               output slot. Channel selection is either round-robin (RR_MODE=1)
//               or driven by an external select (RR_MODE=0). Counts every beat
//               accepted from the inputs.
// Ports       : clock      - single clock, rising edge
//               reset      - synchronous, active-high reset
//               in_data    - NUM_CH packed channels, channel i at [i*WIDTH +: WIDTH]
//               in_valid   - per-channel beat offered
//               in_ready   - per-channel beat accepted (at most one bit high)
//               sel        - channel select, used only when RR_MODE = 0
//               out_data   - registered output beat
//               out_ch     - source channel of out_data
//               out_valid  - output slot holds a beat
//               out_ready  - downstream accepts the output beat
//               xfer_count - 16-bit wrapping count of accepted input beats
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 2,
    parameter int RR_MODE = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [(2**SEL_W)*WIDTH-1:0]   in_data,
    input  logic [(2**SEL_W)-1:0]         in_valid,
    output logic [(2**SEL_W)-1:0]         in_ready,
    input  logic [SEL_W-1:0]              sel,
    output logic [WIDTH-1:0]              out_data,
    output logic [SEL_W-1:0]              out_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   xfer_count
);

    localparam int NUM_CH = 2**SEL_W;

    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_ch_q,     out_ch_d;
    logic             out_valid_q,  out_valid_d;
    logic [15:0]      xfer_count_q, xfer_count_d;
    logic [SEL_W-1:0] rr_ptr_q,     rr_ptr_d;

    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_load_en;
    logic             w_accept;

    // The output slot can take a new beat when it is empty or being drained.
    assign w_load_en = ~out_valid_q | out_ready;
    // Reset gates acceptance so a beat offered during reset is never taken.
    assign w_accept  = w_grant_valid & w_load_en & ~reset;

    generate
        if (RR_MODE != 0) begin : g_rr
            // Search rr_ptr+1, rr_ptr+2, ... rr_ptr+NUM_CH (mod NUM_CH). The loop
            // runs from the farthest candidate to the nearest so the nearest
            // requesting channel is the last assignment and wins.
            always_comb begin
                logic [SEL_W-1:0] idx;
                idx     = '0;
                w_grant = '0;
                for (int k = NUM_CH; k >= 1; k--) begin
                    idx = rr_ptr_q + SEL_W'(k);
                    if (in_valid[idx]) begin
                        w_grant = idx;
                    end
                end
            end
            assign w_grant_valid = |in_valid;
        end else begin : g_sel
            assign w_grant       = sel;
            assign w_grant_valid = in_valid[sel];
        end
    endgenerate

    assign in_ready = w_accept ? (NUM_CH'(1) << w_grant) : '0;

    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        xfer_count_d = xfer_count_q;
        rr_ptr_d     = rr_ptr_q;
        if (w_accept) begin
            out_data_d   = in_data[w_grant*WIDTH +: WIDTH];
            out_ch_d     = w_grant;
            out_valid_d  = 1'b1;
            xfer_count_d = xfer_count_q + 16'd1;
            rr_ptr_d     = w_grant;
        end else if (w_load_en) begin
            // Slot drained with nothing to refill: only the valid flag drops.
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            xfer_count_q <= '0;
            // Pointer at the last channel makes channel 0 the first candidate.
            rr_ptr_q     <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            xfer_count_q <= xfer_count_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width per channel in bits.
REQ-002 The block SHALL have parameter SEL_W, default 2: select/tag width; channel count NUM_CH = 2**SEL_W (default 4).
REQ-003 The block SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = external select.
REQ-004 The block SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid  input  NUM_CH  channel i has a beat offered.
REQ-008 The block SHALL have port in_ready  output  NUM_CH  channel i beat accepted this cycle when in_valid[i] & in_ready[i].
REQ-009 The block SHALL have port sel  input  SEL_W  channel select, used only when RR_MODE = 0.
REQ-010 The block SHALL have port out_data  output  WIDTH  registered output beat.
REQ-011 The block SHALL have port out_ch  output  SEL_W  source channel of out_data.
REQ-012 The block SHALL have port out_valid  output  1  out_data/out_ch hold a beat.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-014 The block SHALL have port xfer_count  output  16  count of beats accepted from inputs.

Function
REQ-015 Output stage SHALL be one register slot; load_en = ~out_valid | out_ready.
REQ-016 At most one in_ready bit SHALL be high per cycle; in_ready[g] = grant_valid & (g == grant) & load_en; all others 0.
REQ-017 RR_MODE=1: grant SHALL be first i with in_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH; grant_valid = |in_valid.
REQ-018 RR_MODE=1: rr_ptr SHALL update to grant only on an accepted beat; otherwise it holds.
REQ-019 RR_MODE=0: grant SHALL equal sel; grant_valid = in_valid[sel]; rr_ptr unused; other channels never see ready.
REQ-020 On acceptance, next cycle out_data SHALL equal the granted channel's in_data, out_ch = grant, out_valid = 1 (latency 1 cycle).
REQ-021 If load_en and no acceptance, out_valid SHALL become 0; out_data and out_ch hold their prior values.
REQ-022 If out_valid & ~out_ready, out_data, out_ch, and out_valid SHALL hold and every in_ready SHALL be 0 (backpressure).
REQ-023 Simultaneous downstream take and upstream accept SHALL sustain one beat per cycle with no bubble.
REQ-024 xfer_count SHALL increment by 1 per accepted input beat and wrap 0xFFFF -> 0x0000.
REQ-025 The in_ready outputs SHALL depend combinationally on in_valid, sel, out_ready, and state; no output SHALL depend on in_data.
REQ-026 Grant SHALL be stable while out_valid & ~out_ready only in the sense that no transfer occurs; rr_ptr does not move.

Reset
REQ-027 While reset is high at a clock edge: out_valid = 0, out_data = 0, out_ch = 0, xfer_count = 0, rr_ptr = NUM_CH-1 (channel 0 highest priority next).
REQ-028 Reset SHALL override any in-flight transfer; a beat presented in the reset cycle is not accepted and not counted.
REQ-029 in_ready SHALL be all 0 during any cycle in which reset is high.

Verification
REQ-030 Reset then in_valid=4'b1111, out_ready=1, distinct data per channel -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 after the first.
REQ-031 in_valid=4'b0101, out_ready=1 -> grants alternate 0,2,0,2; channels 1 and 3 never get in_ready.
REQ-032 One beat 0xDEADBEEF loaded on ch1, out_ready=0 for 3 cycles -> out_data holds 0xDEADBEEF, out_ch=1, in_ready=0; out_ready=1 -> drained, next beat loads the same cycle.
REQ-033 RR_MODE=0, sel=2, in_valid=4'b1111 -> only in_ready[2] high, out_ch=2 every beat; sel=2 with in_valid[2]=0 -> no transfer, out_valid drops.
REQ-034 Force 65,536 accepted beats -> xfer_count wraps to 0x0000; assert reset mid-stream with out_valid=1 -> next cycle out_valid=0, xfer_count=0, following grant goes to channel 0.
